// File: rtl/mxint8_block_quantize_pkg.sv
// Shared constants for the MXINT8 block quantizer: float32 field layout,
// MXINT8 element format, E8M0 NaN scale and FSM state encodings.
package mxint8_block_quantize_pkg;

    localparam int FLOAT32_WIDTH        = 32;
    localparam int FLOAT_SIGN_BIT       = 31;
    localparam int FLOAT_EXP_MSB        = 30;
    localparam int FLOAT_EXP_LSB        = 23;
    localparam int FLOAT_MANT_WIDTH     = 23;

    localparam int SCALE_WIDTH          = 8;
    localparam int MXINT8_ELEMENT_WIDTH = 8;
    localparam int MXINT8_FRAC_BITS     = 6;

    localparam logic [MXINT8_ELEMENT_WIDTH-1:0] MXINT8_MAX_MAG = 8'd127;
    localparam logic [SCALE_WIDTH-1:0]          SCALE_NAN      = 8'hFF;

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_OUTPUT  = 2'd2;

endpackage

// File: rtl/mxint8_element_quantize.sv
// Combinational float32 -> MXINT8 (1.6 two's complement) conversion against a
// shared E8M0 scale, with round-to-nearest-even and saturation to +/-127.
module mxint8_element_quantize
    import mxint8_block_quantize_pkg::*;
(
    input  logic [FLOAT32_WIDTH-1:0]        i_float32,
    input  logic [SCALE_WIDTH-1:0]          i_scale,
    output logic [MXINT8_ELEMENT_WIDTH-1:0] o_element
);

    logic                            sign;
    logic [7:0]                      expField;
    logic [FLOAT_MANT_WIDTH:0]       sig;
    logic [8:0]                      totalShift;
    logic [FLOAT_MANT_WIDTH:0]       kept;
    logic [FLOAT_MANT_WIDTH:0]       rem;
    logic [FLOAT_MANT_WIDTH:0]       half;
    logic [FLOAT_MANT_WIDTH:0]       rounded;
    logic                            roundUp;
    logic [MXINT8_ELEMENT_WIDTH-1:0] mag;

    // The element keeps 6 fraction bits, so the 24-bit significand is shifted
    // right by (23-6) plus the exponent gap to the shared scale.
    always_comb begin
        sign       = i_float32[FLOAT_SIGN_BIT];
        expField   = i_float32[FLOAT_EXP_MSB:FLOAT_EXP_LSB];
        sig        = {1'b1, i_float32[FLOAT_MANT_WIDTH-1:0]};
        totalShift = 9'(FLOAT_MANT_WIDTH - MXINT8_FRAC_BITS) + {1'b0, i_scale - expField};
        kept       = '0;
        rem        = '0;
        half       = '0;
        rounded    = '0;
        roundUp    = 1'b0;
        mag        = '0;

        if (expField == 8'd0 || expField == SCALE_NAN) begin
            mag = '0;
        end else if (expField > i_scale) begin
            mag = MXINT8_MAX_MAG;
        end else if (totalShift >= 9'(FLOAT_MANT_WIDTH + 2)) begin
            mag = '0;
        end else begin
            kept    = sig >> totalShift;
            rem     = sig & ((24'd1 << totalShift) - 24'd1);
            half    = 24'd1 << (totalShift - 9'd1);
            roundUp = (rem > half) || ((rem == half) && kept[0]);
            rounded = kept + 24'(roundUp);
            // Rounding 1.111... up at shift 0 reaches 2.0; saturate instead of bumping the scale.
            mag     = (rounded > 24'(MXINT8_MAX_MAG)) ? MXINT8_MAX_MAG : rounded[7:0];
        end

        o_element = sign ? (~mag + 8'd1) : mag;
    end

endmodule

// File: rtl/mxint8_block_quantize.sv
// Streaming MXINT8 block quantizer: collects BLOCK_SIZE float32 values, derives
// the shared scale from the largest exponent, converts one element per cycle.
module mxint8_block_quantize
    import mxint8_block_quantize_pkg::*;
#(
    parameter int BLOCK_SIZE = 32,
    parameter int CNT_WIDTH  = $clog2(BLOCK_SIZE)
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic [FLOAT32_WIDTH-1:0]        i_float32,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [SCALE_WIDTH-1:0]          o_scale,
    output logic [MXINT8_ELEMENT_WIDTH-1:0] o_mxint8_elements [BLOCK_SIZE]
);

    localparam logic [CNT_WIDTH-1:0] LAST_INDEX = CNT_WIDTH'(BLOCK_SIZE - 1);

    logic [1:0]                      state_q, state_d;
    logic [CNT_WIDTH-1:0]            index_q, index_d;
    logic [SCALE_WIDTH-1:0]          maxExp_q, maxExp_d;
    logic                            nanSeen_q, nanSeen_d;
    logic [SCALE_WIDTH-1:0]          scale_q, scale_d;
    logic [FLOAT32_WIDTH-1:0]        buffer_q   [BLOCK_SIZE];
    logic [MXINT8_ELEMENT_WIDTH-1:0] elements_q [BLOCK_SIZE];

    logic [7:0]                      inExp;
    logic                            accept;
    logic [MXINT8_ELEMENT_WIDTH-1:0] quantElement;

    assign inExp   = i_float32[FLOAT_EXP_MSB:FLOAT_EXP_LSB];
    assign o_ready = (state_q == ST_COLLECT);
    assign o_valid = (state_q == ST_OUTPUT);
    assign accept  = o_ready && i_valid;
    assign o_scale = scale_q;
    assign o_mxint8_elements = elements_q;

    mxint8_element_quantize u_quant (
        .i_float32 (buffer_q[index_q]),
        .i_scale   (maxExp_q),
        .o_element (quantElement)
    );

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        maxExp_d  = maxExp_q;
        nanSeen_d = nanSeen_q;
        scale_d   = scale_q;

        case (state_q)
            ST_COLLECT: begin
                if (i_valid) begin
                    index_d = index_q + 1'b1;
                    if (inExp > maxExp_q) maxExp_d = inExp;
                    if (inExp == SCALE_NAN) nanSeen_d = 1'b1;
                    if (index_q == LAST_INDEX) begin
                        index_d = '0;
                        state_d = ST_CONVERT;
                    end
                end
            end
            ST_CONVERT: begin
                index_d = index_q + 1'b1;
                if (index_q == LAST_INDEX) begin
                    index_d = '0;
                    scale_d = nanSeen_q ? SCALE_NAN : maxExp_q;
                    state_d = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                // Scale tracking restarts here so the next block never sees a stale maximum.
                if (i_ready) begin
                    state_d   = ST_COLLECT;
                    maxExp_d  = '0;
                    nanSeen_d = 1'b0;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_COLLECT;
            index_q   <= '0;
            maxExp_q  <= '0;
            nanSeen_q <= 1'b0;
            scale_q   <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            maxExp_q  <= maxExp_d;
            nanSeen_q <= nanSeen_d;
            scale_q   <= scale_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) buffer_q[index_q] <= i_float32;
    end

    // NaN anywhere in the block makes every element a don't-care; drive zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < BLOCK_SIZE; i++) elements_q[i] <= '0;
        end else if (state_q == ST_CONVERT) begin
            elements_q[index_q] <= nanSeen_q ? '0 : quantElement;
        end
    end

endmodule

// File: tb/tb_mxint8_block_quantize.sv
// Randomized and directed checks of the MXINT8 block quantizer against an
// arithmetic reference model of the scale and element conversion.
module tb_mxint8_block_quantize;

    localparam int BS = 32;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_float32;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_scale;
    logic [7:0]  o_mxint8_elements [BS];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] blockData [BS];
    logic [7:0]  expElem [BS];
    logic [7:0]  expScale;

    mxint8_block_quantize #(.BLOCK_SIZE(BS)) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_valid           (i_valid),
        .o_ready           (o_ready),
        .i_float32         (i_float32),
        .o_valid           (o_valid),
        .i_ready           (i_ready),
        .o_scale           (o_scale),
        .o_mxint8_elements (o_mxint8_elements)
    );

    always #5 i_clk = ~i_clk;

    // Element value = x / 2^(scale-127), expressed in 1/64 units, rounded half-to-even.
    function automatic logic [7:0] refElement(input logic [31:0] f, input int s);
        int     e;
        int     sh;
        longint sig;
        longint den;
        longint q;
        longint r;
        e = int'(f[30:23]);
        if (e == 0) return 8'h00;
        sh = 17 + s - e;
        if (sh >= 40) return 8'h00;
        sig = longint'({1'b1, f[22:0]});
        den = longint'(1) << sh;
        q = sig / den;
        r = sig % den;
        if ((2 * r > den) || ((2 * r == den) && (q % 2 == 1))) q = q + 1;
        if (q > 127) q = 127;
        return f[31] ? 8'(-q) : 8'(q);
    endfunction

    function automatic void buildExpected();
        int mx;
        bit nan;
        mx  = 0;
        nan = 1'b0;
        for (int i = 0; i < BS; i++) begin
            if (int'(blockData[i][30:23]) > mx) mx = int'(blockData[i][30:23]);
            if (blockData[i][30:23] == 8'hFF) nan = 1'b1;
        end
        expScale = nan ? 8'hFF : 8'(mx);
        for (int i = 0; i < BS; i++) expElem[i] = nan ? 8'h00 : refElement(blockData[i], mx);
    endfunction

    function automatic void fillOnes();
        for (int i = 0; i < BS; i++) blockData[i] = 32'h3F800000;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic sendBlock(input bit gaps);
        for (int i = 0; i < BS; i++) begin
            i_valid   = 1'b1;
            i_float32 = blockData[i];
            tick();
            if (gaps && i < BS - 1) begin
                i_valid   = 1'b0;
                i_float32 = $urandom;
                tick();
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic waitValid(output int cycles);
        cycles = 0;
        while (!o_valid && cycles < 200) begin
            tick();
            cycles++;
        end
        if (!o_valid) cycles = -1;
    endtask

    task automatic retire();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_scale !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_ctrl valid=%b ready=%b scale=%h, required 0 1 00", o_valid, o_ready, o_scale);
        end
        for (int i = 0; i < BS; i++) begin
            checks++;
            if (o_mxint8_elements[i] !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_elem[%0d] got %h, required 00", i, o_mxint8_elements[i]);
            end
        end
    endtask

    task automatic test_directed(input string name, input bit gaps);
        int cycles;
        buildExpected();
        sendBlock(gaps);
        waitValid(cycles);
        checks++;
        if (cycles != BS) begin
            errors++;
            $display("[TB] FAIL %s_latency got %0d cycles, required %0d", name, cycles, BS);
        end
        checks++;
        if (o_scale !== expScale) begin
            errors++;
            $display("[TB] FAIL %s_scale got %h, required %h", name, o_scale, expScale);
        end
        for (int i = 0; i < BS; i++) begin
            checks++;
            if (o_mxint8_elements[i] !== expElem[i]) begin
                errors++;
                $display("[TB] FAIL %s_elem[%0d] got %h, required %h", name, i, o_mxint8_elements[i], expElem[i]);
            end
        end
        retire();
    endtask

    task automatic test_all_ones();
        fillOnes();
        test_directed("ones", 1'b0);
        checks++;
        if (expScale !== 8'h7F || expElem[0] !== 8'h40) begin
            errors++;
            $display("[TB] FAIL ones_model scale=%h elem=%h, required 7f 40", expScale, expElem[0]);
        end
    endtask

    task automatic test_mixed_sign();
        fillOnes();
        blockData[0] = 32'h40000000;
        blockData[5] = 32'hBF800000;
        test_directed("mixed", 1'b0);
    endtask

    task automatic test_rne_clamp();
        fillOnes();
        blockData[1] = 32'h3F810000;
        blockData[2] = 32'h3F830000;
        blockData[3] = 32'h3FFFFFFF;
        blockData[4] = 32'hBFFFFFFF;
        blockData[6] = 32'h3A800000;
        blockData[7] = 32'h00400000;
        test_directed("rne", 1'b0);
    endtask

    task automatic test_nan();
        fillOnes();
        blockData[9] = 32'h7FC00000;
        test_directed("nan", 1'b0);
    endtask

    task automatic test_valid_gaps();
        fillOnes();
        blockData[0] = 32'h40000000;
        blockData[5] = 32'hBF800000;
        i_ready = 1'b1;
        buildExpected();
        sendBlock(1'b1);
        i_ready = 1'b0;
        begin
            int cycles;
            waitValid(cycles);
            checks++;
            if (cycles != BS) begin
                errors++;
                $display("[TB] FAIL gaps_latency got %0d, required %0d", cycles, BS);
            end
        end
        checks++;
        if (o_scale !== expScale || o_mxint8_elements[5] !== expElem[5] || o_mxint8_elements[0] !== expElem[0]) begin
            errors++;
            $display("[TB] FAIL gaps_block scale=%h e0=%h e5=%h, required %h %h %h",
                     o_scale, o_mxint8_elements[0], o_mxint8_elements[5], expScale, expElem[0], expElem[5]);
        end
        retire();
    endtask

    task automatic test_output_stall();
        int cycles;
        for (int i = 0; i < BS; i++) blockData[i] = {$urandom_range(1, 0) == 1, 8'($urandom_range(124, 130)), 23'($urandom)};
        buildExpected();
        sendBlock(1'b0);
        waitValid(cycles);
        checks++;
        if (cycles != BS) begin
            errors++;
            $display("[TB] FAIL stall_latency got %0d, required %0d", cycles, BS);
        end
        i_valid   = 1'b1;
        i_float32 = 32'h7F7FFFFF;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_scale !== expScale ||
                o_mxint8_elements[c] !== expElem[c]) begin
                errors++;
                $display("[TB] FAIL stall_hold[%0d] valid=%b ready=%b scale=%h elem=%h, required 1 0 %h %h",
                         c, o_valid, o_ready, o_scale, o_mxint8_elements[c], expScale, expElem[c]);
            end
        end
        retire();
        i_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_retire valid=%b ready=%b, required 0 1", o_valid, o_ready);
        end
        fillOnes();
        test_directed("after_stall", 1'b0);
    endtask

    task automatic test_reset_mid_convert();
        for (int i = 0; i < BS; i++) blockData[i] = 32'h40800000;
        sendBlock(1'b0);
        repeat (7) tick();
        #2;
        i_rst = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_scale !== 8'h00 || o_mxint8_elements[0] !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midreset valid=%b ready=%b scale=%h e0=%h, required 0 1 00 00",
                     o_valid, o_ready, o_scale, o_mxint8_elements[0]);
        end
        #3;
        i_rst = 1'b0;
        tick();
        fillOnes();
        test_directed("post_reset", 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < BS; i++) begin
                if ($urandom_range(9, 0) == 0) blockData[i] = {$urandom_range(1, 0) == 1, 31'd0};
                else blockData[i] = {$urandom_range(1, 0) == 1, 8'($urandom_range(110, 135)), 23'($urandom)};
            end
            if (b == 3) begin
                blockData[2] = 32'h7F000000;
                blockData[8] = 32'hFF7FFFFF;
            end
            test_directed("random", 1'b0);
        end
    endtask

    initial begin
        i_rst     = 1'b1;
        i_valid   = 1'b0;
        i_ready   = 1'b0;
        i_float32 = '0;
        #12;
        test_reset();
        i_rst = 1'b0;
        tick();
        test_all_ones();
        test_mixed_sign();
        test_rne_clamp();
        test_nan();
        test_valid_gaps();
        test_output_stall();
        test_reset_mid_convert();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mxint8_block_quantize.md
Name: mxint8_block_quantize

Overview:
- Streaming quantizer that collects BLOCK_SIZE float32 values, one per cycle, and derives the shared MX scale from the largest biased exponent.
- It then converts every element to MXINT8 against that scale and presents one complete MX block (scale plus elements).
- Sits upstream of the MXINT8 ALU datapath. It is the general-block counterpart of the single-value broadcast converter: same element format, same NaN scale encoding.

Parameters:
- BLOCK_SIZE, 32, elements per MX block; must be a power of two, ≥2.
- CNT_WIDTH, $clog2(BLOCK_SIZE), width of the element index counter.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_valid  input  1  i_float32 valid this cycle.
- o_ready  output  1  block accepts an element this cycle.
- i_float32  input  `FLOAT32_WIDTH (32)  IEEE-754 binary32 element.
- o_valid  output  1  o_scale and o_mxint8_elements hold a complete block.
- i_ready  input  1  consumer takes the block.
- o_scale  output  `SCALE_WIDTH (8)  shared E8M0 scale.
- o_mxint8_elements  output  `MXINT8_ELEMENT_WIDTH (8) x BLOCK_SIZE  unpacked array; two's complement, 1 sign, 1 integer, 6 fraction bits.

Behaviour:
- Reset (async assert, sync deassert):
  - state=COLLECT, index=0, max_exp=0, nan_seen=0.
  - o_valid=0, o_ready=1, o_scale=0, all elements 0.
- FSM states: COLLECT, CONVERT, OUTPUT.
- COLLECT:
  - o_ready=1. On i_valid&&o_ready, write i_float32 to buffer[index] and increment index.
  - max_exp <= max(max_exp, exp). nan_seen |= (exp==8'hFF).
  - On the accept with index==BLOCK_SIZE-1: index wraps to 0, go to CONVERT.
- CONVERT:
  - o_ready=0. One element per cycle: element[index] <= quantize(buffer[index], max_exp), index++.
  - After element BLOCK_SIZE-1: index=0, o_scale <= (nan_seen ? 8'hFF : max_exp), go to OUTPUT.
- OUTPUT:
  - o_valid=1, o_ready=0. Outputs stable until i_valid-independent handshake o_valid&&i_ready.
  - On handshake: o_valid=0, max_exp=0, nan_seen=0, go to COLLECT.
  - Element registers keep their old values until overwritten.
- Latency:
  - BLOCK_SIZE cycles from the edge that accepts the last element to o_valid=1.
  - Throughput is one block per 2*BLOCK_SIZE+1 cycles minimum.
- quantize(x, s):
  - exp==0 (zero/subnormal) → 8'h00. Subnormals are flushed.
  - nan_seen → element 8'h00 (don't-care by the MX standard; driven 0 for determinism).
  - Otherwise:
    - m = {1'b1, mantissa} (24 bits), shift = s - exp (0..254).
    - Right shift m by 17+shift with round-to-nearest-even on the discarded bits. Shifts ≥25 give 0.
    - Rounded magnitude is 8 bits unsigned. If it reaches 128 (shift=0, mantissa rounds to 2.0), clamp to 127; no scale bump.
    - sign=1 → two's-complement negate the magnitude. 127 becomes 8'h81; -128 never produced.
- Boundaries:
  - i_valid low in COLLECT: hold, no counter change.
  - i_ready asserted outside OUTPUT: ignored.
  - i_valid during CONVERT/OUTPUT: not accepted (o_ready=0).
  - Reset mid-CONVERT or mid-OUTPUT: block discarded, reset values apply immediately.
  - max_exp=8'hFE with all elements finite: normal path, scale 8'hFE.

Decomposition:
- mxint8_includes.v gains the following, shared by all MX blocks:
  - MXINT8_FRAC_BITS=6
  - MXINT8_MAX_MAG=127
  - SCALE_NAN=8'hFF
  - FSM state encodings (COLLECT=2'd0, CONVERT=2'd1, OUTPUT=2'd2)
- scalar_includes.v supplies the FLOAT32 field macros.
- One combinational sub-module, mxint8_element_quantize, implements quantize(x, s): inputs float32 and scale, output 8-bit element. It is unit-tested separately.

Test Plan:
- All 32 elements 0x3F800000 (1.0) → o_valid exactly 32 cycles after the last accept; o_scale=0x7F; all elements 0x40.
- Element 0 = 0x40000000 (2.0), others 0x3F800000, element 5 = 0xBF800000 (-1.0) → o_scale=0x80; e0=0x40; e5=0xE0; others 0x20.
- RNE and clamp, others 1.0:
  - e1=0x3F810000 → 0x40 (tie, even).
  - e2=0x3F830000 → 0x42 (tie, odd up).
  - e3=0x3FFFFFFF → 0x7F (clamp).
  - e4=0xBFFFFFFF → 0x81.
  - e6=0x3A800000 (2^-10) → 0x00.
- One element 0x7FC00000 (NaN), rest 1.0 → o_scale=0xFF, all elements 0x00.
- Handshake stalls:
  - i_valid toggled every other cycle during COLLECT → same result as the back-to-back case.
  - Hold i_ready=0 for 10 cycles in OUTPUT → outputs stable, o_ready=0; block retires on the i_ready pulse.
  - Next block starts accepting the cycle after.
- Assert i_rst mid-CONVERT (after 7 elements converted) → o_valid=0, o_ready=1, o_scale=0 asynchronously.
  - Next full block of 1.0 after release → o_scale=0x7F, elements 0x40 (no stale max_exp).
